uart_rx: RTL and testbench

Serial receiver for the UART path: it recovers 8N1 frames from the asynchronous `rx` line using the 16x oversampling `tick` from the baud rate generator. Each good frame produces one byte on `rx_data` with a one-cycle `rx_valid` strobe. Frames with a bad stop bit produce a one-cycle `frame_err` strobe instead. It sits between the device pin and the receive-side consumer (FIFO or register interface).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and default constants for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_2ff
// Description : Two-flop synchronizer for an asynchronous level, resets high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver using a 16x oversampling tick, mid-bit sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] c_TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [TW-1:0]        r_tick_cnt;
    logic [TW-1:0]        w_tick_cnt_nxt;
    logic [BW-1:0]        r_bit_cnt;
    logic [BW-1:0]        w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;
    logic                 w_stop_sample;
    logic                 w_valid_nxt;
    logic                 w_ferr_nxt;
    logic                 w_busy_nxt;

    uart_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        if (tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt    = START;
                        w_tick_cnt_nxt = '0;
                    end
                end
                START: begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        // A start bit that is high again at mid-bit was only a glitch
                        if (!w_rx_s) begin
                            w_state_nxt    = DATA;
                            w_tick_cnt_nxt = '0;
                            w_bit_cnt_nxt  = '0;
                        end else begin
                            w_state_nxt    = IDLE;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_shift_nxt    = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tick_cnt_nxt = '0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_nxt   = STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
                STOP: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_state_nxt    = IDLE;
                        w_tick_cnt_nxt = '0;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_stop_sample = tick && (r_state == STOP) && (r_tick_cnt == c_TICK_LAST);
        w_valid_nxt   = w_stop_sample && w_rx_s;
        w_ferr_nxt    = w_stop_sample && !w_rx_s;
        w_busy_nxt    = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= w_busy_nxt;
            if (w_valid_nxt) begin
                r_data <= r_shift;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx: frame table, corner cases, random frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int BIT_TICKS = 16;
    // Line edge -> detection is 3 tick edges when tick runs every clk, then 152 to the stop sample
    localparam longint LATENCY = 3 + 152;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int     checks = 0;
    int     errors = 0;
    int     tick_div = 1;
    int     div_cnt = 0;
    longint tick_edges = 0;
    bit     prev_strobe = 1'b0;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        longint     t;
    } ev_t;
    ev_t evq[$];

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         gap;
        bit         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[6];

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_cnt >= tick_div - 1) begin
            div_cnt = 0;
            tick    = 1'b1;
        end else begin
            div_cnt = div_cnt + 1;
            tick    = 1'b0;
        end
    end

    always @(posedge clk) if (tick) tick_edges++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1 || frame_err === 1'b1) begin
            check("strobe_exclusive", 64'(rx_valid & frame_err), 64'd0);
            check("strobe_single_cycle", 64'(prev_strobe), 64'd0);
            evq.push_back('{ferr: frame_err, data: rx_data, t: tick_edges});
        end
        prev_strobe = rx_valid | frame_err;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, output longint start);
        start = tick_edges;
        rx = 1'b0;
        wait_ticks(BIT_TICKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_ticks(BIT_TICKS);
        end
        rx = stop_ok;
        wait_ticks(BIT_TICKS);
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string name, input bit exp_ferr, input logic [7:0] exp_data,
                                input longint start, input bit chk_t, output longint t);
        ev_t ev;
        t = 0;
        check({name, "_event_count"}, 64'(evq.size()), 64'd1);
        if (evq.size() > 0) begin
            ev = evq.pop_front();
            t  = ev.t;
            check({name, "_frame_err"}, 64'(ev.ferr), 64'(exp_ferr));
            check({name, "_rx_data"}, 64'(rx_data), 64'(exp_data));
            if (!exp_ferr) check({name, "_strobe_data"}, 64'(ev.data), 64'(exp_data));
            if (chk_t) check({name, "_latency"}, 64'(ev.t - start), 64'(LATENCY));
        end
        evq.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint start;
        longint t;
        longint prev_t;
        logic [7:0] last_good;

        vecs[0] = '{8'hA5, 1'b1, 4, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 8, 1'b1, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 4, 1'b0, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 2, 1'b0, 8'h81};
        vecs[5] = '{8'h7E, 1'b0, 8, 1'b1, 8'h81};

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_rx_data", 64'(rx_data), 64'h00);
        check("reset_rx_valid", 64'(rx_valid), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        wait_ticks(20);

        // Frame table, tick every clk; back-to-back spacing checked where gap is zero
        prev_t = 0;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok, start);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_ferr, vecs[i].exp_data, start, 1'b1, t);
            if (i > 0 && vecs[i-1].gap == 0)
                check($sformatf("vec%0d_b2b_spacing", i), 64'(t - prev_t), 64'd160);
            prev_t = t;
            wait_ticks(vecs[i].gap);
        end
        wait_ticks(20);

        // Start glitch: low for 4 ticks only
        start = tick_edges;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        check("glitch_busy_high", 64'(busy), 64'd1);
        wait_ticks(6);
        check("glitch_busy_before_fall", 64'(busy), 64'd1);
        wait_ticks(1);
        check("glitch_busy_fall", 64'(busy), 64'd0);
        wait_ticks(200);
        check("glitch_no_strobe", 64'(evq.size()), 64'd0);
        check("glitch_rx_data_hold", 64'(rx_data), 64'h81);

        // Reset after three data bits
        rx = 1'b0;
        wait_ticks(BIT_TICKS);
        for (int i = 0; i < 3; i++) begin
            rx = ((i % 2) == 0);
            wait_ticks(BIT_TICKS);
        end
        rst = 1'b1;
        #2;
        check("midreset_rx_data", 64'(rx_data), 64'h00);
        check("midreset_rx_valid", 64'(rx_valid), 64'd0);
        check("midreset_frame_err", 64'(frame_err), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(200);
        check("midreset_no_strobe", 64'(evq.size()), 64'd0);
        send_frame(8'h5A, 1'b1, start);
        expect_frame("after_reset", 1'b0, 8'h5A, start, 1'b1, t);
        wait_ticks(10);

        // Random frames against the byte/stop-bit model, random tick rate
        tick_div  = $urandom_range(1, 3);
        wait_ticks(4);
        last_good = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            bit         ok;
            int         gap;
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            gap = ok ? int'($urandom_range(0, 10)) : int'($urandom_range(8, 16));
            if (ok) last_good = b;
            send_frame(b, ok, start);
            expect_frame($sformatf("rand%0d", i), !ok, last_good, start, 1'b0, t);
            wait_ticks(gap);
        end

        wait_ticks(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
